// File: rtl/gtc_pkg.sv
// Shared definitions for the gate truth-table checker: FSM states, last vector
// index and the expected response of the gate under test.
package gtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CHECK,
        FIN
    } gtc_state_e;

    localparam logic [2:0] VEC_LAST = 3'd7;

    function automatic logic nand3(input logic [2:0] v);
        return ~(&v);
    endfunction

endpackage

// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between the checker and its environment.
// fail_vec/fail_vld exist only when GTC_FIRST_FAIL_EN is defined.
interface gate_truth_checker_if #(
    parameter int unsigned ERR_W = 4
);
    logic             start;
    logic             d;
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
`ifdef GTC_FIRST_FAIL_EN
    logic [2:0]       fail_vec;
    logic             fail_vld;
`endif

    modport master (
        output start, d,
`ifdef GTC_FIRST_FAIL_EN
        input  fail_vec, fail_vld,
`endif
        input  a, b, c, busy, done, pass, err_cnt
    );

    modport slave (
        input  start, d,
`ifdef GTC_FIRST_FAIL_EN
        output fail_vec, fail_vld,
`endif
        output a, b, c, busy, done, pass, err_cnt
    );

endinterface

// File: rtl/gtc_settle_timer.sv
// Settle down-counter: load arms it for SETTLE_CYC cycles, tick counts down,
// zero flags the last settle cycle.
module gtc_settle_timer #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic zero
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= 4'(SETTLE_CYC - 1);
        end else if (tick && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps all eight {a,b,c} vectors into a 3-input gate and checks d against NAND3.
// Optional first-failure capture enabled by defining GTC_FIRST_FAIL_EN.
module gate_truth_checker
    import gtc_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned ERR_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_truth_checker_if.slave  bus
);

    gtc_state_e       state_q;
    logic [2:0]       vec_q;
    logic [2:0]       abc_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_d;
    logic             mismatch;
    logic             settle_zero;
`ifdef GTC_FIRST_FAIL_EN
    logic [2:0]       fail_vec_q;
    logic             fail_vld_q;
`endif

    gtc_settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_q == APPLY),
        .tick  (state_q == WAIT),
        .zero  (settle_zero)
    );

    assign mismatch = (state_q == CHECK) && (bus.d != nand3(abc_q));
    assign err_d    = (mismatch && !(&err_q)) ? err_q + ERR_W'(1) : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            abc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
`ifdef GTC_FIRST_FAIL_EN
            fail_vec_q <= '0;
            fail_vld_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        vec_q      <= '0;
                        abc_q      <= '0;
                        err_q      <= '0;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef GTC_FIRST_FAIL_EN
                        fail_vec_q <= '0;
                        fail_vld_q <= 1'b0;
`endif
                        state_q    <= APPLY;
                    end
                end
                APPLY: state_q <= WAIT;
                WAIT: begin
                    if (settle_zero) state_q <= CHECK;
                end
                CHECK: begin
                    err_q <= err_d;
`ifdef GTC_FIRST_FAIL_EN
                    if (mismatch && !fail_vld_q) begin
                        fail_vec_q <= vec_q;
                        fail_vld_q <= 1'b1;
                    end
`endif
                    // Outputs for FIN are registered here so they are visible in the FIN cycle itself.
                    if (vec_q == VEC_LAST) begin
                        abc_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        state_q <= FIN;
                    end else begin
                        vec_q   <= vec_q + 3'd1;
                        abc_q   <= vec_q + 3'd1;
                        state_q <= APPLY;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a       = abc_q[2];
    assign bus.b       = abc_q[1];
    assign bus.c       = abc_q[0];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;
`ifdef GTC_FIRST_FAIL_EN
    assign bus.fail_vec = fail_vec_q;
    assign bus.fail_vld = fail_vld_q;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three instances (S=2/W=4, S=2/W=2 with d tied low,
// S=1 with a one-cycle-delayed NAND3), a cycle-position model and literal checks.
module tb_gate_truth_checker;

    logic clk;
    logic rst_n;
    logic start;
    int   d_mode;
    logic d2_q;

    int n_checks;
    int n_errors;

    // Per-instance model state: settle cycles, error ceiling, sweep position.
    int       m_s[3];
    int       m_wmax[3];
    bit       m_act[3];
    int       m_k[3];
    bit [7:0] m_mask[3];
    int       m_lerr[3];
    bit       m_lpass[3];
    int       m_lfv[3];
    bit       m_lfvld[3];

    gate_truth_checker_if #(.ERR_W(4)) if0 ();
    gate_truth_checker_if #(.ERR_W(2)) if1 ();
    gate_truth_checker_if #(.ERR_W(4)) if2 ();

    gate_truth_checker #(.SETTLE_CYC(2), .ERR_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    gate_truth_checker #(.SETTLE_CYC(2), .ERR_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    gate_truth_checker #(.SETTLE_CYC(1), .ERR_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    assign if0.start = start;
    assign if1.start = start;
    assign if2.start = start;
    assign if0.d = (d_mode == 0) ? ~(if0.a & if0.b & if0.c) : (d_mode == 1);
    assign if1.d = 1'b0;
    assign if2.d = d2_q;

    always @(posedge clk) d2_q <= ~(if2.a & if2.b & if2.c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Gate response as seen at sampling time for a response mode.
    function automatic bit resp(input int mode, input int v);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return (v != 7);
    endfunction

    function automatic bit [7:0] mask_for(input int mode);
        bit [7:0] m = '0;
        for (int v = 0; v < 8; v++) m[v] = (resp(mode, v) != (v != 7));
        return m;
    endfunction

    function automatic int errs_before(input int i, input int k);
        int n = 0;
        for (int v = 0; v < 8; v++)
            if (m_mask[i][v] && ((v + 1) * (m_s[i] + 2) < k)) n++;
        return (n > m_wmax[i]) ? m_wmax[i] : n;
    endfunction

    function automatic int first_before(input int i, input int k);
        for (int v = 0; v < 8; v++)
            if (m_mask[i][v] && ((v + 1) * (m_s[i] + 2) < k)) return v;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_k[i] = 0; m_lerr[i] = 0; m_lpass[i] = 0; m_lfv[i] = 0; m_lfvld[i] = 0;
        end
    endtask

    task automatic model_edge();
        int fin;
        int f;
        for (int i = 0; i < 3; i++) begin
            fin = 8 * (m_s[i] + 2) + 1;
            if (m_act[i]) begin
                if (m_k[i] == fin) begin
                    m_act[i]   = 0;
                    m_lerr[i]  = errs_before(i, fin);
                    m_lpass[i] = (m_lerr[i] == 0);
                    f = first_before(i, fin);
                    m_lfvld[i] = (f >= 0);
                    m_lfv[i]   = (f >= 0) ? f : 0;
                end else begin
                    m_k[i]++;
                end
            end else if (start) begin
                m_act[i]  = 1;
                m_k[i]    = 1;
                m_mask[i] = mask_for((i == 0) ? d_mode : ((i == 1) ? 2 : 0));
            end
        end
    endtask

    task automatic cmp(input int i, input int abc, input int busy, input int done, input int pass,
                       input int err, input int fv, input int fvld);
        int fin;
        int eabc, ebusy, edone, epass, eerr, efv, efvld, f;
        fin = 8 * (m_s[i] + 2) + 1;
        if (m_act[i]) begin
            ebusy = (m_k[i] <= fin - 1);
            edone = (m_k[i] == fin);
            eabc  = ebusy ? (m_k[i] - 1) / (m_s[i] + 2) : 0;
            eerr  = errs_before(i, m_k[i]);
            epass = edone && (eerr == 0);
            f     = first_before(i, m_k[i]);
            efvld = (f >= 0);
            efv   = (f >= 0) ? f : 0;
        end else begin
            ebusy = 0; edone = 0; eabc = 0;
            eerr = m_lerr[i]; epass = m_lpass[i]; efv = m_lfv[i]; efvld = m_lfvld[i];
        end
        chk($sformatf("d%0d_abc", i), abc, eabc);
        chk($sformatf("d%0d_busy", i), busy, ebusy);
        chk($sformatf("d%0d_done", i), done, edone);
        chk($sformatf("d%0d_pass", i), pass, epass);
        chk($sformatf("d%0d_err_cnt", i), err, eerr);
`ifdef GTC_FIRST_FAIL_EN
        chk($sformatf("d%0d_fail_vld", i), fvld, efvld);
        chk($sformatf("d%0d_fail_vec", i), fv, efv);
`endif
    endtask

    task automatic compare_all();
`ifdef GTC_FIRST_FAIL_EN
        cmp(0, int'({if0.a, if0.b, if0.c}), int'(if0.busy), int'(if0.done), int'(if0.pass),
            int'(if0.err_cnt), int'(if0.fail_vec), int'(if0.fail_vld));
        cmp(1, int'({if1.a, if1.b, if1.c}), int'(if1.busy), int'(if1.done), int'(if1.pass),
            int'(if1.err_cnt), int'(if1.fail_vec), int'(if1.fail_vld));
        cmp(2, int'({if2.a, if2.b, if2.c}), int'(if2.busy), int'(if2.done), int'(if2.pass),
            int'(if2.err_cnt), int'(if2.fail_vec), int'(if2.fail_vld));
`else
        cmp(0, int'({if0.a, if0.b, if0.c}), int'(if0.busy), int'(if0.done), int'(if0.pass),
            int'(if0.err_cnt), 0, 0);
        cmp(1, int'({if1.a, if1.b, if1.c}), int'(if1.busy), int'(if1.done), int'(if1.pass),
            int'(if1.err_cnt), 0, 0);
        cmp(2, int'({if2.a, if2.b, if2.c}), int'(if2.busy), int'(if2.done), int'(if2.pass),
            int'(if2.err_cnt), 0, 0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    // Pulse start, then run ncyc cycles; re-pulse start during cycles rep1/rep2.
    task automatic run_sweep(input int ncyc, input int rep1, input int rep2,
                             output int dc0, output int dc1, output int dc2, output int nd0);
        dc0 = -1; dc1 = -1; dc2 = -1; nd0 = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            if (if0.done) begin
                nd0++;
                if (dc0 < 0) dc0 = n;
            end
            if (if1.done && dc1 < 0) dc1 = n;
            if (if2.done && dc2 < 0) dc2 = n;
            if (n == 33) chk("busy_cycle33", int'(if0.busy), 0);
            start = (n == rep1) || (n == rep2);
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        int dc0, dc1, dc2, nd0;
        n_checks = 0;
        n_errors = 0;
        m_s[0] = 2; m_s[1] = 2; m_s[2] = 1;
        m_wmax[0] = 15; m_wmax[1] = 3; m_wmax[2] = 15;
        m_mask[0] = '0; m_mask[1] = '0; m_mask[2] = '0;
        rst_n  = 1'b0;
        start  = 1'b0;
        d_mode = 0;
        model_reset();
        idle(3);
        chk("rst_busy", int'(if0.busy), 0);
        chk("rst_err_cnt", int'(if0.err_cnt), 0);
        chk("rst_pass", int'(if0.pass), 0);
        chk("rst_abc", int'({if0.a, if0.b, if0.c}), 0);
        rst_n = 1'b1;
        idle(2);

        // Ideal NAND3 on every instance.
        run_sweep(40, 0, 0, dc0, dc1, dc2, nd0);
        chk("ideal_done_cycle", dc0, 33);
        chk("ideal_done_count", nd0, 1);
        chk("ideal_pass", int'(if0.pass), 1);
        chk("ideal_err_cnt", int'(if0.err_cnt), 0);
        chk("delayed_s1_done_cycle", dc2, 25);
        chk("delayed_s1_pass", int'(if2.pass), 1);
        chk("w2_done_cycle", dc1, 33);
        chk("w2_err_sat", int'(if1.err_cnt), 3);
        chk("w2_pass", int'(if1.pass), 0);
        idle(30);

        // d stuck high: only vector 7 mismatches.
        d_mode = 1;
        run_sweep(40, 0, 0, dc0, dc1, dc2, nd0);
        chk("hi_err_cnt", int'(if0.err_cnt), 1);
        chk("hi_pass", int'(if0.pass), 0);
`ifdef GTC_FIRST_FAIL_EN
        chk("hi_fail_vec", int'(if0.fail_vec), 7);
        chk("hi_fail_vld", int'(if0.fail_vld), 1);
`endif
        idle(30);

        // d stuck low: vectors 0..6 mismatch.
        d_mode = 2;
        run_sweep(40, 0, 0, dc0, dc1, dc2, nd0);
        chk("lo_err_cnt", int'(if0.err_cnt), 7);
        chk("lo_pass", int'(if0.pass), 0);
`ifdef GTC_FIRST_FAIL_EN
        chk("lo_fail_vec", int'(if0.fail_vec), 0);
        chk("lo_fail_vld", int'(if0.fail_vld), 1);
`endif
        idle(30);

        // start re-pulsed mid-sweep and during FIN.
        d_mode = 0;
        run_sweep(40, 5, 33, dc0, dc1, dc2, nd0);
        chk("rep_done_cycle", dc0, 33);
        chk("rep_done_count", nd0, 1);
        chk("rep_pass", int'(if0.pass), 1);
        idle(30);

        // Asynchronous reset in cycle 10 of a sweep.
        start = 1'b1;
        step();
        start = 1'b0;
        idle(9);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("midrst_busy", int'(if0.busy), 0);
        chk("midrst_abc", int'({if0.a, if0.b, if0.c}), 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        run_sweep(40, 0, 0, dc0, dc1, dc2, nd0);
        chk("postrst_done_cycle", dc0, 33);
        chk("postrst_pass", int'(if0.pass), 1);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 SETTLE_CYC, default 2: cycles between stimulus update and sampling d; legal range 1..15.
REQ-002 ERR_W, default 4: width of err_cnt; legal range 2..8.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a full truth-table sweep.
REQ-006 d  input  1  response of the 3-input gate under test.
REQ-007 a, b, c  output  1 each  registered stimulus; {a,b,c} = vector index, a is the MSB.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse at the end of a sweep.
REQ-010 pass  output  1  held high when the last sweep had zero mismatches.
REQ-011 err_cnt  output  ERR_W  saturating mismatch count for the last or current sweep.
REQ-012 fail_vec  output  3  and  fail_vld  output  1: present only when the Configuration macro is defined.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY, WAIT, CHECK and FIN.
REQ-014 IDLE with start=1 SHALL:
- clear vec, err_cnt and pass;
- move to APPLY.
REQ-015 APPLY SHALL last 1 cycle and drive {a,b,c}=vec.
REQ-016 WAIT SHALL last exactly SETTLE_CYC cycles, with {a,b,c} held.
REQ-017 CHECK SHALL last 1 cycle, sample d and compare it with expected = ~(a&b&c).
- On mismatch, err_cnt SHALL increment, saturating at all-ones.
REQ-018 CHECK exit:
- vec==3'd7 SHALL go to FIN;
- otherwise vec SHALL increment and the FSM SHALL go to APPLY.
REQ-019 FIN SHALL last 1 cycle, then return to IDLE. During FIN:
- done=1;
- pass=(err_cnt==0), held until the next accepted start;
- {a,b,c} SHALL return to 3'b000.
REQ-020 busy SHALL be 1 in APPLY, WAIT and CHECK, and 0 in IDLE and FIN.
REQ-021 Per-vector cost SHALL be SETTLE_CYC+2 cycles.
- done SHALL be high in cycle 8*(SETTLE_CYC+2)+1 after the start edge (33 at default).
REQ-022 start SHALL be ignored in every state except IDLE, including FIN.
REQ-023 vec SHALL never wrap; a sweep covers 000..111 exactly once.
REQ-024 err_cnt SHALL hold its value between sweeps and change only on start or a CHECK mismatch.

Reset
REQ-025 When rst_n=0, asynchronously:
- FSM=IDLE; vec=0; a=b=c=0;
- busy=0; done=0; pass=0; err_cnt=0;
- fail_vec=0 and fail_vld=0 when present.
REQ-026 Reset mid-sweep SHALL abort the sweep with no done pulse; the next start after release SHALL run a full sweep.

Configuration
REQ-027 Macro GTC_FIRST_FAIL_EN.
- Defined: fail_vec and fail_vld exist. On the first CHECK mismatch of a sweep, fail_vec SHALL capture vec and fail_vld SHALL go to 1. Later mismatches SHALL leave both unchanged. An accepted start SHALL clear both.
- Undefined: neither port nor any storage exists; all other behaviour is identical.

Structure
REQ-028 Shared package gtc_pkg SHALL hold:
- the FSM state enum;
- VEC_LAST = 3'd7;
- the expected-response function (NAND3).
REQ-029 The settle down-counter SHALL be a sub-module gtc_settle_timer, with load, tick and zero outputs; all other logic SHALL stay in the top module.

Verification
REQ-030 Ideal NAND3 model on d, SETTLE_CYC=2, single start pulse -> done in cycle 33, pass=1, err_cnt=0, busy low in cycle 33.
REQ-031 d tied to 1 -> err_cnt=1, pass=0, fail_vec=3'b111, fail_vld=1.
REQ-032 d tied to 0 -> err_cnt=7, pass=0, fail_vec=3'b000; with ERR_W=2, err_cnt saturates at 3.
REQ-033 start re-pulsed in cycles 5 and 33 -> both ignored; exactly one done, in cycle 33.
REQ-034 rst_n low in cycle 10 mid-sweep -> outputs reset immediately with no done; a new start after release gives done 33 cycles later, pass=1.
REQ-035 SETTLE_CYC=1 with a d model delayed by 1 cycle -> done in cycle 25, pass=1; same model with SETTLE_CYC=0 is out of range and not required.
